stream_spill_reg: RTL and testbench
===================================

Name: stream_spill_reg

Overview:
- Two-entry spill register between a valid/ready stream producer and a STREAM_DV-style consumer.
- Cuts every combinational path between the two sides:
  - valid_o and data_o come straight from flops.
  - ready_o comes straight from a flop.
- Sustains full throughput (one beat per cycle) and holds data_o stable while it is stalled, so it meets the stream-interface stability assertions.
- Sits directly upstream of stream consumers in long or timing-critical handshake chains.

Parameters:
- DATA_WIDTH, 32: payload width in bits; must be at least 1.
- STALL_CNT_WIDTH, 16: width of the stall counter; used only when the optional feature is enabled.

Ports:
- clk_i  in  1  clock; all flops are rising-edge.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous discard of all stored beats.
- valid_i  in  1  upstream beat valid.
- ready_o  out  1  upstream ready; registered.
- data_i  in  DATA_WIDTH  upstream payload.
- valid_o  out  1  downstream beat valid; registered.
- ready_i  in  1  downstream ready.
- data_o  out  DATA_WIDTH  downstream payload; registered.
- stall_cnt_o  out  STALL_CNT_WIDTH  saturating count of stalled cycles; present only with STREAM_SPILL_STALL_CNT_EN.

Behaviour:
- Storage:
  - Slot A (output slot) drives valid_o = a_full and data_o = a_data.
  - Slot B (spill slot) gives ready_o = !b_full.
- Reset values: a_full = 0, b_full = 0, so valid_o = 0 and ready_o = 1. Data flops are reset to 0 and stall_cnt_o to 0.
- Handshakes: in_hs = valid_i & ready_o; out_hs = valid_o & ready_i.
- Latency: a beat accepted in cycle N appears on valid_o/data_o in cycle N+1 at the earliest.
- Ordering is strict FIFO. No beat is dropped or duplicated except by flush_i or reset.
- Per-cycle next state, evaluated in priority order:
  1. Slot A fill. If out_hs or !a_full:
     - If b_full, A takes B's beat and B is cleared.
     - Otherwise, if in_hs, A takes data_i.
     - Otherwise, A is cleared.
  2. Slot B spill. If A stays full with no out_hs and in_hs occurs, B captures data_i. This is the only path into B.
- Case in_hs, out_hs and b_full all in the same cycle:
  - A takes B's beat.
  - This case cannot occur: ready_o = 0 whenever b_full.
- Stability: while valid_o = 1 and ready_i = 0, valid_o remains 1 and data_o does not change in the next cycle.
- Upstream obligations are unchanged: the producer may not drop valid_i or change data_i before in_hs. The block does not check this.
- Full: b_full = 1 means two beats are stored and ready_o = 0 in the same cycle. Throughput of one beat per cycle is kept with ready_i held high.
- Empty: valid_o = 0. A beat arriving while empty sits only in A, never in B.
- Flush:
  - flush_i = 1 clears a_full and b_full at the next edge. Any in_hs in that cycle is discarded.
  - The cycle after a flush: valid_o = 0, ready_o = 1.
  - An out_hs that occurs in the flush cycle still counts as delivered.
- Reset mid-operation: rst_i asserted forces the reset values asynchronously. Stored beats are lost. The first edge after deassertion behaves as if empty.
- No flop is enabled when it is not written. Data flops load only on capture so data_o toggles only on a new beat.

Optional Feature:
- Macro: STREAM_SPILL_STALL_CNT_EN.
- Defined:
  - Port stall_cnt_o exists.
  - Increments by 1 each cycle with valid_o = 1 and ready_i = 0.
  - Saturates at all ones.
  - Cleared by rst_i or flush_i. Flush has priority over increment.
- Undefined: the port and the counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then valid_i = 1 with data_i = 0x11, 0x22, 0x33 on consecutive cycles and ready_i = 1 throughout -> valid_o rises one cycle after the first accept; data_o = 0x11, 0x22, 0x33 on consecutive cycles; ready_o stays 1.
- Fill with ready_i = 0, offering 0xA0 then 0xA1 -> ready_o drops to 0 the cycle after the second accept; data_o holds 0xA0 stable for 5 stalled cycles; release ready_i -> 0xA0 then 0xA1 come out in order; ready_o returns to 1 one cycle after the first out_hs.
- Random valid_i and ready_i over 10 000 cycles with an incrementing payload -> the scoreboard sees every beat exactly once and in order; data_o is stable while stalled; ready_o = 0 only when two beats are stored.
- Two beats stored, then flush_i = 1 for one cycle with valid_i = 1 and data_i = 0xFF -> next cycle valid_o = 0 and ready_o = 1; 0xFF is never emitted.
- rst_i asserted between clock edges with two beats stored -> valid_o = 0 and ready_o = 1 immediately, without waiting for an edge; after release, a new beat 0x55 is output one cycle after accept.
- With STREAM_SPILL_STALL_CNT_EN and STALL_CNT_WIDTH = 4 -> hold a stall for 20 cycles: stall_cnt_o = 15 (saturated); flush_i -> 0 the following cycle.

Source files
------------

// File: rtl/stream_spill_reg.sv
// Two-entry spill register that cuts every combinational path between a valid/ready
// producer and consumer. Optional stall counter: define STREAM_SPILL_STALL_CNT_EN.
module stream_spill_reg #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned STALL_CNT_WIDTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [DATA_WIDTH-1:0]      data_i,
    output logic                       valid_o,
    input  logic                       ready_i,
`ifdef STREAM_SPILL_STALL_CNT_EN
    output logic [STALL_CNT_WIDTH-1:0] stall_cnt_o,
`endif
    output logic [DATA_WIDTH-1:0]      data_o
);

    if (DATA_WIDTH < 1 || STALL_CNT_WIDTH < 1) begin : g_param_check
        $error("stream_spill_reg: DATA_WIDTH and STALL_CNT_WIDTH must be at least 1");
    end

    logic                  a_full_d, a_full_q;
    logic                  b_full_d, b_full_q;
    logic                  ready_d, ready_q;
    logic [DATA_WIDTH-1:0] a_data_d, a_data_q;
    logic [DATA_WIDTH-1:0] b_data_d, b_data_q;
    logic                  a_data_en, b_data_en;
    logic                  in_hs, out_hs, a_load;

    assign in_hs  = valid_i & ready_q;
    assign out_hs = a_full_q & ready_i;
    // Slot A may refill whenever its current beat leaves or it holds nothing.
    assign a_load = out_hs | ~a_full_q;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        a_full_d  = a_full_q;
        b_full_d  = b_full_q;
        a_data_d  = a_data_q;
        b_data_d  = b_data_q;
        a_data_en = 1'b0;
        b_data_en = 1'b0;

        if (a_load) begin
            if (b_full_q) begin
                a_full_d  = 1'b1;
                a_data_d  = b_data_q;
                a_data_en = 1'b1;
                b_full_d  = 1'b0;
            end else if (in_hs) begin
                a_full_d  = 1'b1;
                a_data_d  = data_i;
                a_data_en = 1'b1;
            end else begin
                a_full_d  = 1'b0;
            end
        end else if (in_hs) begin
            b_full_d  = 1'b1;
            b_data_d  = data_i;
            b_data_en = 1'b1;
        end

        if (flush_i) begin
            a_full_d  = 1'b0;
            b_full_d  = 1'b0;
            a_data_en = 1'b0;
            b_data_en = 1'b0;
        end

        // ready_o is its own flop so the upstream side sees no logic after the register.
        ready_d = ~b_full_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_full_q <= 1'b0;
            b_full_q <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            a_full_q <= a_full_d;
            b_full_q <= b_full_d;
            ready_q  <= ready_d;
        end
    end

    // NOTE: payload flops are reset too, so data_o is a known 0 rather than X before the first beat.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_data_q <= '0;
            b_data_q <= '0;
        end else begin
            if (a_data_en) a_data_q <= a_data_d;
            if (b_data_en) b_data_q <= b_data_d;
        end
    end

    assign valid_o = a_full_q;
    assign data_o  = a_data_q;
    assign ready_o = ready_q;

`ifdef STREAM_SPILL_STALL_CNT_EN
    logic [STALL_CNT_WIDTH-1:0] stall_cnt_d, stall_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (flush_i) begin
            stall_cnt_d = '0;
        end else if (a_full_q && !ready_i && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_stream_spill_reg.sv
// Scoreboard bench for stream_spill_reg; expected beats are queued on accept
// and compared against data_o on every downstream handshake.
module tb_stream_spill_reg;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          flush_i;
    logic          valid_i;
    logic          ready_o;
    logic [DW-1:0] data_i;
    logic          valid_o;
    logic          ready_i;
    logic [DW-1:0] data_o;
`ifdef STREAM_SPILL_STALL_CNT_EN
    logic [CW-1:0] stall_cnt_o;
`endif

    stream_spill_reg #(
        .DATA_WIDTH      (DW),
        .STALL_CNT_WIDTH (CW)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
`ifdef STREAM_SPILL_STALL_CNT_EN
        .stall_cnt_o (stall_cnt_o),
`endif
        .data_o  (data_o)
    );

    always #5 clk_i = ~clk_i;

    int unsigned   total = 0;
    int unsigned   bad   = 0;
    logic [DW-1:0] sb_q[$];
    logic          last_in_hs;
    logic          prev_stall;
    logic [DW-1:0] prev_data;

    // Called at negedge+1 with inputs already applied: checks outputs against the
    // model, then advances the model by the handshakes of the coming edge.
    task automatic observe();
        logic [DW-1:0] exp_d;
        total++;
        if (valid_o !== (sb_q.size() != 0)) begin
            bad++;
            $display("FAIL valid_occupancy: valid_o=%b stored=%0d", valid_o, sb_q.size());
        end
        total++;
        if (ready_o !== (sb_q.size() < 2)) begin
            bad++;
            $display("FAIL ready_occupancy: ready_o=%b stored=%0d", ready_o, sb_q.size());
        end
        if (prev_stall) begin
            total++;
            if (valid_o !== 1'b1 || data_o !== prev_data) begin
                bad++;
                $display("FAIL stall_stable: valid_o=%b data_o=%h required valid 1 data %h",
                         valid_o, data_o, prev_data);
            end
        end
        if (valid_o === 1'b1 && ready_i) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL spurious_beat: data_o=%h with nothing stored", data_o);
            end else begin
                exp_d = sb_q.pop_front();
                if (data_o !== exp_d) begin
                    bad++;
                    $display("FAIL beat_order: data_o=%h required %h", data_o, exp_d);
                end
            end
        end
        last_in_hs = valid_i && (ready_o === 1'b1) && !flush_i;
        if (flush_i) sb_q.delete();
        else if (last_in_hs) sb_q.push_back(data_i);
        prev_stall = (valid_o === 1'b1) && !ready_i && !flush_i;
        prev_data  = data_o;
    endtask

    task automatic drive_cycle(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
        valid_i = v;
        data_i  = d;
        ready_i = r;
        flush_i = f;
        #1;
        observe();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        total++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1 || data_o !== '0) begin
            bad++;
            $display("FAIL reset_values: valid_o=%b ready_o=%b data_o=%h required 0 1 0",
                     valid_o, ready_o, data_o);
        end
`ifdef STREAM_SPILL_STALL_CNT_EN
        total++;
        if (stall_cnt_o !== '0) begin
            bad++;
            $display("FAIL reset_stall_cnt: got %0d required 0", stall_cnt_o);
        end
`endif
        rst_i = 1'b0;
        sb_q.delete();
        prev_stall = 1'b0;
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_throughput();
        drive_cycle(1'b1, 32'h11, 1'b1, 1'b0);
        total++;
        if (valid_o !== 1'b1 || data_o !== 32'h11) begin
            bad++;
            $display("FAIL first_latency: valid_o=%b data_o=%h required 1 11", valid_o, data_o);
        end
        drive_cycle(1'b1, 32'h22, 1'b1, 1'b0);
        total++;
        if (data_o !== 32'h22 || ready_o !== 1'b1) begin
            bad++;
            $display("FAIL stream_22: data_o=%h ready_o=%b required 22 1", data_o, ready_o);
        end
        drive_cycle(1'b1, 32'h33, 1'b1, 1'b0);
        total++;
        if (data_o !== 32'h33 || ready_o !== 1'b1) begin
            bad++;
            $display("FAIL stream_33: data_o=%h ready_o=%b required 33 1", data_o, ready_o);
        end
        repeat (2) drive_cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_fill_stall();
        drive_cycle(1'b1, 32'hA0, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'hA1, 1'b0, 1'b0);
        total++;
        if (ready_o !== 1'b0) begin
            bad++;
            $display("FAIL full_ready: ready_o=%b required 0", ready_o);
        end
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b0, '0, 1'b0, 1'b0);
            total++;
            if (data_o !== 32'hA0 || valid_o !== 1'b1 || ready_o !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold_%0d: data_o=%h valid_o=%b ready_o=%b required a0 1 0",
                         i, data_o, valid_o, ready_o);
            end
        end
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        total++;
        if (data_o !== 32'hA1 || ready_o !== 1'b1) begin
            bad++;
            $display("FAIL release_order: data_o=%h ready_o=%b required a1 1", data_o, ready_o);
        end
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        total++;
        if (valid_o !== 1'b0) begin
            bad++;
            $display("FAIL drained: valid_o=%b required 0", valid_o);
        end
    endtask

    task automatic test_random();
        logic          pend_v = 1'b0;
        logic [DW-1:0] pend_d = '0;
        logic [DW-1:0] payload = 32'h1000;
        for (int i = 0; i < 10000; i++) begin
            if (!pend_v) begin
                pend_v = ($urandom_range(0, 9) < 6);
                pend_d = payload;
            end
            drive_cycle(pend_v, pend_d, ($urandom_range(0, 9) < ((i < 5000) ? 6 : 9)), 1'b0);
            if (last_in_hs) begin
                payload++;
                pend_v = 1'b0;
            end
        end
        for (int i = 0; i < 8 && sb_q.size() != 0; i++) drive_cycle(1'b0, '0, 1'b1, 1'b0);
        total++;
        if (sb_q.size() != 0 || valid_o !== 1'b0) begin
            bad++;
            $display("FAIL random_drain: stored=%0d valid_o=%b required 0 0", sb_q.size(), valid_o);
        end
    endtask

    task automatic test_flush();
        drive_cycle(1'b1, 32'h01, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'h02, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'hFF, 1'b0, 1'b1);
        total++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            bad++;
            $display("FAIL flush_full: valid_o=%b ready_o=%b required 0 1", valid_o, ready_o);
        end
        repeat (3) drive_cycle(1'b0, '0, 1'b1, 1'b0);
        drive_cycle(1'b1, 32'h03, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'hFE, 1'b0, 1'b1);
        total++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            bad++;
            $display("FAIL flush_discard: valid_o=%b ready_o=%b required 0 1", valid_o, ready_o);
        end
        drive_cycle(1'b1, 32'h04, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'h05, 1'b1, 1'b1);
        repeat (2) drive_cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        drive_cycle(1'b1, 32'h31, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'h32, 1'b0, 1'b0);
        valid_i = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        total++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            bad++;
            $display("FAIL async_reset: valid_o=%b ready_o=%b required 0 1", valid_o, ready_o);
        end
        sb_q.delete();
        prev_stall = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        drive_cycle(1'b1, 32'h55, 1'b1, 1'b0);
        total++;
        if (valid_o !== 1'b1 || data_o !== 32'h55) begin
            bad++;
            $display("FAIL post_reset_beat: valid_o=%b data_o=%h required 1 55", valid_o, data_o);
        end
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

`ifdef STREAM_SPILL_STALL_CNT_EN
    task automatic test_stall_cnt();
        drive_cycle(1'b0, '0, 1'b1, 1'b1);
        drive_cycle(1'b1, 32'h77, 1'b0, 1'b0);
        repeat (3) drive_cycle(1'b0, '0, 1'b0, 1'b0);
        total++;
        if (stall_cnt_o !== CW'(3)) begin
            bad++;
            $display("FAIL stall_cnt_count: got %0d required 3", stall_cnt_o);
        end
        repeat (17) drive_cycle(1'b0, '0, 1'b0, 1'b0);
        total++;
        if (stall_cnt_o !== CW'(15)) begin
            bad++;
            $display("FAIL stall_cnt_saturate: got %0d required 15", stall_cnt_o);
        end
        drive_cycle(1'b0, '0, 1'b0, 1'b1);
        total++;
        if (stall_cnt_o !== '0 || valid_o !== 1'b0) begin
            bad++;
            $display("FAIL stall_cnt_flush: cnt=%0d valid_o=%b required 0 0", stall_cnt_o, valid_o);
        end
    endtask
`endif

    initial begin
        rst_i      = 1'b1;
        flush_i    = 1'b0;
        valid_i    = 1'b0;
        ready_i    = 1'b0;
        data_i     = '0;
        prev_stall = 1'b0;
        prev_data  = '0;
        last_in_hs = 1'b0;
        test_reset();
        test_throughput();
        test_fill_stall();
        test_random();
        test_flush();
        test_async_reset();
`ifdef STREAM_SPILL_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
